// File: rtl/tpu_host_sequencer_if.sv
// Bundles the host job stream, the result stream, the matrix-multiply
// controller load/readback lines and the status flags of the host sequencer.
interface tpu_host_sequencer_if;
  // host job stream
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  // controller load / readback side
  logic       tpu_rst;
  logic       load_en;
  logic       load_sel_ab;
  logic [1:0] load_index;
  logic [7:0] in_data;
  logic       output_en;
  logic [1:0] output_sel;
  logic [7:0] out_data;
  logic       done;
  // result stream
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  // status
  logic       busy;
  logic       err;

  // sequencer side
  modport master (
    input  s_valid, s_data, out_data, done, m_ready,
    output s_ready, tpu_rst, load_en, load_sel_ab, load_index, in_data,
           output_en, output_sel, m_valid, m_data, m_last, busy, err
  );

  // environment side (host, controller and result sink)
  modport slave (
    output s_valid, s_data, out_data, done, m_ready,
    input  s_ready, tpu_rst, load_en, load_sel_ab, load_index, in_data,
           output_en, output_sel, m_valid, m_data, m_last, busy, err
  );
endinterface

// File: rtl/tpu_host_sequencer.sv
// Host-side sequencer for the matrix-multiply controller: loads an 8-byte
// job (A0..A3, B0..B3), waits for done with a timeout, then reads C0..C3
// back out on a valid/ready stream. The controller is reset before every job.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_TPU_RST   | tpu_rst held high for TPU_RST_CYCLES cycles
// S_LOAD      | accepting job bytes, one load_en pulse per accepted byte
// S_WAIT_DONE | waiting for done, aborts with err after TIMEOUT_CYCLES
// S_READ      | walking output_sel 0..3, streaming C0..C3 with m_last on C3
module tpu_host_sequencer #(
  parameter int TPU_RST_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                  clk_i,
  input logic                  rst_i,
  tpu_host_sequencer_if.master bus_io
);

  localparam int RW = (TPU_RST_CYCLES > 1) ? $clog2(TPU_RST_CYCLES) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST  = RW'(TPU_RST_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_TPU_RST   = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_READ      = 2'd3
  } state_t;

  state_t        state_q;
  logic [RW-1:0] rst_cnt_q;
  logic [2:0]    byte_cnt_q;
  logic [2:0]    rd_idx_q;     // bit 2 set once C3 has been captured
  logic [WW-1:0] wait_cnt_q;

  logic       tpu_rst_q;
  logic       load_en_q;
  logic       load_sel_ab_q;
  logic [1:0] load_index_q;
  logic [7:0] in_data_q;
  logic       output_en_q;
  logic [1:0] output_sel_q;
  logic       m_valid_q;
  logic [7:0] m_data_q;
  logic       m_last_q;
  logic       err_q;

  logic accept;
  logic capture;

  // Byte accept and result capture qualifiers.
  assign accept  = (state_q == S_LOAD) && bus_io.s_valid;
  assign capture = (state_q == S_READ) && !rd_idx_q[2] &&
                   (!m_valid_q || bus_io.m_ready);

  // Sequencer FSM with registered controller and stream outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_TPU_RST;
      rst_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      rd_idx_q      <= '0;
      wait_cnt_q    <= '0;
      tpu_rst_q     <= 1'b1;
      load_en_q     <= 1'b0;
      load_sel_ab_q <= 1'b0;
      load_index_q  <= '0;
      in_data_q     <= '0;
      output_en_q   <= 1'b0;
      output_sel_q  <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      load_en_q <= 1'b0;
      case (state_q)
        S_TPU_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q   <= S_LOAD;
            rst_cnt_q <= '0;
            tpu_rst_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + RW'(1);
          end
        end
        S_LOAD: begin
          if (accept) begin
            load_en_q     <= 1'b1;
            in_data_q     <= bus_io.s_data;
            load_sel_ab_q <= byte_cnt_q[2];
            load_index_q  <= byte_cnt_q[1:0];
            byte_cnt_q    <= byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd7) begin
              state_q    <= S_WAIT_DONE;
              wait_cnt_q <= '0;
            end
          end
        end
        S_WAIT_DONE: begin
          if (bus_io.done) begin
            state_q      <= S_READ;
            wait_cnt_q   <= '0;
            rd_idx_q     <= '0;
            output_en_q  <= 1'b1;
            output_sel_q <= '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q    <= S_TPU_RST;
            wait_cnt_q <= '0;
            rst_cnt_q  <= '0;
            tpu_rst_q  <= 1'b1;
            err_q      <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WW'(1);
          end
        end
        S_READ: begin
          if (capture) begin
            m_data_q     <= bus_io.out_data;
            m_valid_q    <= 1'b1;
            m_last_q     <= (rd_idx_q == 3'd3);
            rd_idx_q     <= rd_idx_q + 3'd1;
            output_sel_q <= rd_idx_q[1:0] + 2'd1;
            if (rd_idx_q == 3'd3) begin
              output_en_q <= 1'b0;
            end
          end else if (m_valid_q && bus_io.m_ready) begin
            m_valid_q <= 1'b0;
            if (m_last_q) begin
              m_last_q  <= 1'b0;
              state_q   <= S_TPU_RST;
              rst_cnt_q <= '0;
              tpu_rst_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_TPU_RST;
        end
      endcase
    end
  end

  assign bus_io.s_ready     = (state_q == S_LOAD);
  assign bus_io.busy        = !((state_q == S_LOAD) && (byte_cnt_q == 3'd0));
  assign bus_io.tpu_rst     = tpu_rst_q;
  assign bus_io.load_en     = load_en_q;
  assign bus_io.load_sel_ab = load_sel_ab_q;
  assign bus_io.load_index  = load_index_q;
  assign bus_io.in_data     = in_data_q;
  assign bus_io.output_en   = output_en_q;
  assign bus_io.output_sel  = output_sel_q;
  assign bus_io.m_valid     = m_valid_q;
  assign bus_io.m_data      = m_data_q;
  assign bus_io.m_last      = m_last_q;
  assign bus_io.err         = err_q;

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Bench for tpu_host_sequencer: a behavioural 2x2 matrix-multiply controller,
// a monitor/scoreboard for load writes and result beats, a job table with
// hand-computed products, directed corner sequences and random jobs.
module tb_tpu_host_sequencer;
  localparam int N_RST = 2;
  localparam int N_TO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpu_host_sequencer_if bus ();

  tpu_host_sequencer #(.TPU_RST_CYCLES(N_RST), .TIMEOUT_CYCLES(N_TO)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // C = A x B for 2x2 byte matrices, results modulo 256.
  // job byte i at [8*i +: 8]: A0..A3 then B0..B3, row-major.
  function automatic logic [31:0] matmul(input logic [63:0] j);
    logic [31:0] c;
    int s;
    c = '0;
    for (int r = 0; r < 2; r++) begin
      for (int q = 0; q < 2; q++) begin
        s = 0;
        for (int k = 0; k < 2; k++)
          s += int'(j[8*(2*r+k) +: 8]) * int'(j[8*(4+2*k+q) +: 8]);
        c[8*(2*r+q) +: 8] = s[7:0];
      end
    end
    return c;
  endfunction

  // ---------------- behavioural controller ----------------
  logic [7:0]  a_m [4] = '{default: 8'd0};
  logic [7:0]  b_m [4] = '{default: 8'd0};
  logic [63:0] mem_job;
  logic [31:0] c_now;
  int loads_seen = 0;
  int dcnt = 0;
  bit done_en = 1'b1;

  always @(posedge clk) begin
    if (bus.tpu_rst === 1'b1) begin
      loads_seen <= 0;
      dcnt <= 0;
    end else if (bus.load_en === 1'b1) begin
      if (bus.load_sel_ab) b_m[bus.load_index] <= bus.in_data;
      else                 a_m[bus.load_index] <= bus.in_data;
      loads_seen <= loads_seen + 1;
      if (loads_seen == 7) dcnt <= 4;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
    end
  end

  assign mem_job      = {b_m[3], b_m[2], b_m[1], b_m[0], a_m[3], a_m[2], a_m[1], a_m[0]};
  assign c_now        = matmul(mem_job);
  assign bus.out_data = c_now[{bus.output_sel, 3'b000} +: 8];
  assign bus.done     = done_en && (dcnt == 1);

  // ---------------- monitor / scoreboard ----------------
  typedef struct { logic sel; logic [1:0] idx; logic [7:0] data; int cyc; } ld_t;
  typedef struct { logic [7:0] d; logic last; } res_t;
  ld_t  ld_q [$];
  res_t res_q [$];
  logic [7:0] got_c [$];
  ld_t  le;
  res_t re;
  logic [31:0] cexp;
  logic [63:0] jb = '0;
  int pos = 0, cyc = 0, mv_cnt = 0;
  int tr_rise = 0, hs_cyc = 0;
  bit tr_pend = 0, hs_pend = 0;
  logic prev_mv = 0, prev_mr = 0, prev_ml = 0, prev_sr = 0, prev_tr = 0;
  logic [7:0] prev_md = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      ld_q.delete();
      res_q.delete();
      pos = 0;
      tr_pend = 0;
      hs_pend = 0;
      prev_mv = 0; prev_mr = 0; prev_ml = 0; prev_sr = 0; prev_tr = 0;
    end else begin
      if (bus.load_en) begin
        if (ld_q.size() == 0) chk("load_en unexpected", 32'(1), 32'(0));
        else begin
          le = ld_q.pop_front();
          chk("load_sel_ab", 32'(bus.load_sel_ab), 32'(le.sel));
          chk("load_index", 32'(bus.load_index), 32'(le.idx));
          chk("in_data", 32'(bus.in_data), 32'(le.data));
          chk("load latency", 32'(cyc), 32'(le.cyc));
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        ld_q.push_back('{sel: (pos >= 4), idx: 2'(pos % 4), data: bus.s_data, cyc: cyc + 1});
        jb[8*pos +: 8] = bus.s_data;
        pos++;
        if (pos == 8) begin
          pos = 0;
          if (done_en) begin
            cexp = matmul(jb);
            for (int k = 0; k < 4; k++)
              res_q.push_back('{d: cexp[8*k +: 8], last: (k == 3)});
          end
        end
      end
      if (prev_mv && !prev_mr) begin
        chk("hold m_valid", 32'(bus.m_valid), 32'(1));
        chk("hold m_data", 32'(bus.m_data), 32'(prev_md));
        chk("hold m_last", 32'(bus.m_last), 32'(prev_ml));
      end
      if (bus.m_valid) mv_cnt++;
      if (bus.m_valid && bus.m_ready) begin
        if (res_q.size() == 0) chk("m_valid unexpected", 32'(1), 32'(0));
        else begin
          re = res_q.pop_front();
          chk("m_data", 32'(bus.m_data), 32'(re.d));
          chk("m_last", 32'(bus.m_last), 32'(re.last));
        end
        got_c.push_back(bus.m_data);
        if (bus.m_last) begin
          hs_cyc = cyc;
          hs_pend = 1;
        end
      end
      if (bus.tpu_rst && !prev_tr) begin
        if (hs_pend) begin
          chk("tpu_rst after C3", 32'(cyc - hs_cyc), 32'(1));
          hs_pend = 0;
        end
        tr_rise = cyc;
        tr_pend = 1;
      end
      if (bus.s_ready && !prev_sr && tr_pend) begin
        chk("tpu_rst length", 32'(cyc - tr_rise), 32'(N_RST));
        tr_pend = 0;
      end
      prev_mv = bus.m_valid;
      prev_mr = bus.m_ready;
      prev_md = bus.m_data;
      prev_ml = bus.m_last;
      prev_sr = bus.s_ready;
      prev_tr = bus.tpu_rst;
    end
  end

  // ---------------- stimulus ----------------
  bit rnd_ready = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) bus.m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic put_byte(input logic [7:0] d);
    int t;
    t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    @(negedge clk);
    while (!bus.s_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("s_ready wait bound", 32'(0), 32'(1));
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic send_job(input logic [63:0] job, input bit gappy);
    for (int i = 0; i < 8; i++) begin
      put_byte(job[8*i +: 8]);
      if (gappy) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((res_q.size() != 0 || !bus.s_ready) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("job completion bound", 32'(0), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst tpu_rst", 32'(bus.tpu_rst), 32'(1));
    chk("rst load_en", 32'(bus.load_en), 32'(0));
    chk("rst load_sel_ab", 32'(bus.load_sel_ab), 32'(0));
    chk("rst load_index", 32'(bus.load_index), 32'(0));
    chk("rst in_data", 32'(bus.in_data), 32'(0));
    chk("rst output_en", 32'(bus.output_en), 32'(0));
    chk("rst output_sel", 32'(bus.output_sel), 32'(0));
    chk("rst m_valid", 32'(bus.m_valid), 32'(0));
    chk("rst m_data", 32'(bus.m_data), 32'(0));
    chk("rst m_last", 32'(bus.m_last), 32'(0));
    chk("rst s_ready", 32'(bus.s_ready), 32'(0));
    chk("rst err", 32'(bus.err), 32'(0));
    chk("rst busy", 32'(bus.busy), 32'(1));
  endtask

  task automatic check_c(input string name, input int base, input logic [31:0] exp);
    for (int k = 0; k < 4; k++)
      chk(name, 32'(got_c[base + k]), 32'(exp[8*k +: 8]));
  endtask

  typedef struct { logic [63:0] job; logic [31:0] exp_c; bit gappy; } vec_t;
  vec_t vecs [5];

  initial begin
    int mv_before;
    logic [63:0] rj;

    // job = {B3,B2,B1,B0,A3,A2,A1,A0}, exp_c = {C3,C2,C1,C0}
    vecs[0] = '{job: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                exp_c: {8'd50, 8'd43, 8'd22, 8'd19}, gappy: 1'b0};
    vecs[1] = '{job: {8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'd0, 8'd0, 8'd1},
                exp_c: {8'd6, 8'd7, 8'd8, 8'd9}, gappy: 1'b1};
    vecs[2] = '{job: {8{8'd16}}, exp_c: 32'd0, gappy: 1'b0};
    vecs[3] = '{job: {8'd1, 8'd1, 8'd1, 8'd1, 8'd255, 8'd255, 8'd255, 8'd255},
                exp_c: {4{8'd254}}, gappy: 1'b0};
    vecs[4] = '{job: {8'd4, 8'd3, 8'd2, 8'd1, 8'd3, 8'd0, 8'd0, 8'd2},
                exp_c: {8'd12, 8'd9, 8'd4, 8'd2}, gappy: 1'b1};

    bus.s_valid = 1'b0;
    bus.s_data  = 8'd0;
    bus.m_ready = 1'b1;

    // reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_idle();
    chk("idle busy", 32'(bus.busy), 32'(0));

    // table of jobs, m_ready held high
    for (int v = 0; v < 5; v++) begin
      got_c.delete();
      send_job(vecs[v].job, vecs[v].gappy);
      wait_idle();
      chk("result count", 32'(got_c.size()), 32'(4));
      if (got_c.size() == 4) check_c("table C", 0, vecs[v].exp_c);
    end

    // backpressure: hold C0 for 5 cycles
    got_c.delete();
    bus.m_ready = 1'b0;
    send_job(vecs[0].job, 1'b0);
    begin
      int t;
      t = 0;
      @(negedge clk);
      while (!bus.m_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("m_valid wait bound", 32'(0), 32'(1));
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp m_data C0", 32'(bus.m_data), 32'(19));
      chk("bp m_last", 32'(bus.m_last), 32'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    wait_idle();
    chk("bp result count", 32'(got_c.size()), 32'(4));
    if (got_c.size() == 4) check_c("bp C", 0, vecs[0].exp_c);

    // timeout: done never arrives
    done_en = 1'b0;
    mv_before = mv_cnt;
    send_job(vecs[0].job, 1'b0);
    @(negedge clk);              // first WAIT_DONE cycle
    repeat (15) @(negedge clk);
    chk("err before timeout", 32'(bus.err), 32'(0));
    @(negedge clk);
    chk("err after timeout", 32'(bus.err), 32'(1));
    chk("tpu_rst after timeout", 32'(bus.tpu_rst), 32'(1));
    chk("no m_valid on timeout", 32'(mv_cnt), 32'(mv_before));
    done_en = 1'b1;
    wait_idle();
    got_c.delete();
    send_job(vecs[4].job, 1'b0);
    wait_idle();
    chk("post-timeout count", 32'(got_c.size()), 32'(4));
    if (got_c.size() == 4) check_c("post-timeout C", 0, vecs[4].exp_c);
    chk("err sticky", 32'(bus.err), 32'(1));

    // reset in the middle of a load
    for (int i = 0; i < 5; i++) put_byte(8'(i + 100));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    wait_idle();
    got_c.delete();
    send_job(vecs[0].job, 1'b0);
    wait_idle();
    chk("post-reset count", 32'(got_c.size()), 32'(4));
    if (got_c.size() == 4) check_c("post-reset C", 0, vecs[0].exp_c);

    // back-to-back jobs
    got_c.delete();
    send_job(vecs[0].job, 1'b0);
    send_job(vecs[4].job, 1'b0);
    wait_idle();
    chk("b2b count", 32'(got_c.size()), 32'(8));
    if (got_c.size() == 8) begin
      check_c("b2b C first", 0, vecs[0].exp_c);
      check_c("b2b C second", 4, vecs[4].exp_c);
    end

    // random jobs, random gaps and backpressure, checked by the scoreboard
    rnd_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      got_c.delete();
      rj = {$urandom, $urandom};
      send_job(rj, bit'($urandom_range(0, 1)));
      wait_idle();
      chk("random count", 32'(got_c.size()), 32'(4));
    end
    rnd_ready = 1'b0;
    bus.m_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tpu_host_sequencer.md
Name: tpu_host_sequencer

Overview:
- Host-side driver for the matrix-multiply controller's byte-wide load/readback interface.
- Accepts an 8-byte job stream (A0..A3, then B0..B3) on a valid/ready input and issues the load_en/load_sel_ab/load_index/in_data writes.
- Pulses the controller's reset between jobs, waits for done, then walks output_sel 0..3 and returns C0..C3 on a valid/ready output stream with a last flag.

Parameters:
- TPU_RST_CYCLES, 2, cycles tpu_rst is held high before each job (min 1).
- TIMEOUT_CYCLES, 64, max WAIT_DONE cycles before abort (min 1).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- s_valid  input  1  job byte valid
- s_data  input  8  job byte, order A0,A1,A2,A3,B0,B1,B2,B3
- s_ready  output  1  sequencer accepts s_data this cycle
- tpu_rst  output  1  reset to controller, active high
- load_en  output  1  controller load strobe
- load_sel_ab  output  1  0=A, 1=B
- load_index  output  2  element index
- in_data  output  8  element byte
- output_en  output  1  controller readback enable
- output_sel  output  2  C element select
- out_data  input  8  C element from controller (combinational from output_sel)
- done  input  1  controller completion (pulse or level)
- m_valid  output  1  result byte valid
- m_data  output  8  result byte C0..C3
- m_last  output  1  high with C3
- m_ready  input  1  downstream accepts result
- busy  output  1  high in any state except LOAD with byte count 0
- err  output  1  sticky timeout flag

Behaviour:
- Reset: on rst, state=TPU_RST, rst_cnt=0, byte_cnt=0, rd_idx=0, wait_cnt=0. Outputs: tpu_rst=1, load_en=0, load_sel_ab=0, load_index=0, in_data=0, output_en=0, output_sel=0, m_valid=0, m_data=0, m_last=0, s_ready=0, err=0, busy=1. rst mid-job discards all job state and loses any in-flight result.
- States: TPU_RST -> LOAD -> WAIT_DONE -> READ -> TPU_RST. WAIT_DONE -> TPU_RST on timeout.
- TPU_RST:
  - tpu_rst=1 for exactly TPU_RST_CYCLES cycles, counted from entry, then LOAD.
  - s_ready=0; load_en=0.
- LOAD:
  - s_ready=1 (combinational from state).
  - On s_valid&&s_ready: next cycle load_en=1 for one cycle, in_data=s_data, load_sel_ab=byte_cnt[2], load_index=byte_cnt[1:0]; byte_cnt increments.
  - One accept per cycle max; back-to-back accepts give back-to-back load_en pulses.
  - After the 8th accept: s_ready=0 from the next cycle. The state moves to WAIT_DONE in the same cycle the 8th load_en is driven. byte_cnt wraps to 0.
  - s_valid low: hold, no load_en; load_sel_ab/load_index/in_data keep their last values.
- WAIT_DONE:
  - wait_cnt increments each cycle.
  - done sampled high (any cycle in WAIT_DONE, including the first): next state READ, wait_cnt=0.
  - wait_cnt reaching TIMEOUT_CYCLES-1 with done low: err<=1, next state TPU_RST, no output produced.
  - done high outside WAIT_DONE is ignored.
- READ:
  - output_en=1, output_sel=rd_idx.
  - When m_valid==0 or (m_valid&&m_ready): register m_data=out_data, m_valid=1, m_last=(rd_idx==3), rd_idx++.
  - m_data/m_valid/m_last hold stable while m_valid&&!m_ready.
  - After the C3 byte is captured, output_en=0 and no further capture occurs.
  - Leave READ for TPU_RST on the cycle the C3 beat handshakes (m_valid&&m_ready&&m_last); m_valid=0 next cycle unless rst.
  - Worst case 4 bytes in 4 cycles with m_ready tied high.
- err: cleared only by rst; it does not block further jobs.
- Latency, m_ready=1, s_valid continuous:
  - 8 accept cycles, then done wait.
  - First m_valid 1 cycle after READ entry; C3 is valid 3 cycles later.
  - TPU_RST_CYCLES gap before the next s_ready.

Test Plan:
- Single job: A=[1,2,3,4], B=[5,6,7,8], model done 4 cycles after last load, m_ready=1 -> load_en pulses idx 0..3 sel 0 then 0..3 sel 1. m_data driven from model C=[19,22,43,50]; m_last only on 50; then tpu_rst high 2 cycles.
- Gappy input: s_valid toggles every other cycle -> exactly 8 load_en pulses, each one cycle after its accept, in_data matches; no load_en while s_valid low.
- Backpressure: m_ready low 5 cycles after first m_valid -> m_data=C0 held stable; all 4 bytes delivered in order, none duplicated or dropped.
- Timeout: done never asserted, TIMEOUT_CYCLES=16 -> err=1 after 16 WAIT_DONE cycles, no m_valid, tpu_rst re-asserted, next job completes normally with err still 1.
- Reset mid-load: rst after 5 accepts -> all outputs at reset values next cycle, tpu_rst=1; a fresh 8-byte job then produces correct C.
- Back-to-back jobs: two jobs queued, m_ready=1 -> second job's s_ready rises exactly TPU_RST_CYCLES cycles after first C3 handshake; both C sets correct.
